// File: rtl/traffic_pkg.sv
// Light codes, lamp bit positions and driver state encoding shared by the
// phase controller and the lamp driver.
package traffic_pkg;

  typedef logic [2:0] code_t;

  localparam code_t RED           = 3'd0;
  localparam code_t GREEN         = 3'd1;
  localparam code_t YELLOW        = 3'd2;
  localparam code_t LEFT          = 3'd3;
  localparam code_t GREEN_TWINKLE = 3'd4;

  localparam int CAR_RED    = 0;
  localparam int CAR_YELLOW = 1;
  localparam int CAR_GREEN  = 2;
  localparam int CAR_LEFT   = 3;

  localparam int WLK_RED   = 0;
  localparam int WLK_GREEN = 1;

  typedef enum logic [1:0] {
    ST_ARM   = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

endpackage

// File: rtl/blink_phase.sv
// Blink phase generator: o_lit is the value to register on this edge; restart
// forces phase 0 (lit), enable advances a 2*BLINK_HALF wrap, otherwise cleared.
module blink_phase #(
  parameter int BLINK_HALF = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_enable,
  input  logic i_restart,
  output logic o_lit
);

  localparam int CW = $clog2(2 * BLINK_HALF);
  localparam logic [CW-1:0] LAST = CW'(2 * BLINK_HALF - 1);
  localparam logic [CW-1:0] HALF = CW'(BLINK_HALF);

  // Holds the phase index that the next edge will display.
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_restart) begin
      r_cnt <= CW'(1);
    end else if (i_enable) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  assign o_lit = i_restart | (i_enable & (r_cnt < HALF));

endmodule

// File: rtl/signal_lamp_driver.sv
// Registered one-hot lamp driver with walker twinkle and a latching safety
// monitor; 1-cycle decode latency, no flow control (inputs sampled every cycle).
module signal_lamp_driver
  import traffic_pkg::*;
#(
  parameter int STARTUP_CYCLES = 2,
  parameter int BLINK_HALF     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] h_car_code,
  input  logic [2:0] v_car_code,
  input  logic [2:0] h_walker_code,
  input  logic [2:0] v_walker_code,
  output logic [3:0] h_car_lamp,
  output logic [3:0] v_car_lamp,
  output logic [1:0] h_walker_lamp,
  output logic [1:0] v_walker_lamp,
  output logic       fault,
  output logic [1:0] fault_cause
);

  localparam int AW = $clog2(STARTUP_CYCLES + 2);

  function automatic logic [3:0] car_decode(input code_t c);
    logic [3:0] l;
    l = '0;
    case (c)
      GREEN:   l[CAR_GREEN]  = 1'b1;
      YELLOW:  l[CAR_YELLOW] = 1'b1;
      LEFT:    l[CAR_LEFT]   = 1'b1;
      default: l[CAR_RED]    = 1'b1;
    endcase
    return l;
  endfunction

  function automatic logic [1:0] walker_decode(input code_t c, input logic lit);
    logic [1:0] l;
    l = '0;
    case (c)
      GREEN:         l[WLK_GREEN] = 1'b1;
      GREEN_TWINKLE: l[WLK_GREEN] = lit;
      default:       l[WLK_RED]   = 1'b1;
    endcase
    return l;
  endfunction

  function automatic logic car_illegal(input code_t c);
    return c > LEFT;
  endfunction

  function automatic logic walker_illegal(input code_t c);
    return !((c == RED) || (c == GREEN) || (c == GREEN_TWINKLE));
  endfunction

  function automatic logic conflict(input code_t hc, input code_t vc,
                                    input code_t hw, input code_t vw);
    return ((hc != RED) && (vc != RED)) ||
           ((hw != RED) && (hc != RED)) ||
           ((vw != RED) && (vc != RED));
  endfunction

  state_t        r_state;
  state_t        w_next_state;
  logic [AW-1:0] r_arm_cnt;
  code_t         r_hw_prev;
  code_t         r_vw_prev;
  logic [3:0]    r_h_car;
  logic [3:0]    r_v_car;
  logic [1:0]    r_h_wlk;
  logic [1:0]    r_v_wlk;
  logic          r_fault;
  logic [1:0]    r_cause;

  logic [3:0] w_h_car_nxt;
  logic [3:0] w_v_car_nxt;
  logic [1:0] w_h_wlk_nxt;
  logic [1:0] w_v_wlk_nxt;
  logic       w_fault_nxt;
  logic [1:0] w_cause_nxt;
  logic       w_flash_restart;
  logic       w_arm_done;
  logic       w_conf;
  logic       w_ill;
  logic       w_run;
  logic       w_h_en;
  logic       w_v_en;
  logic       w_h_restart;
  logic       w_v_restart;
  logic       w_h_lit;
  logic       w_v_lit;
  logic       w_flash_lit;

  assign w_run       = (r_state == ST_RUN);
  assign w_arm_done  = (int'(r_arm_cnt) >= STARTUP_CYCLES - 1);
  assign w_conf      = conflict(h_car_code, v_car_code, h_walker_code, v_walker_code);
  assign w_ill       = car_illegal(h_car_code) | car_illegal(v_car_code) |
                       walker_illegal(h_walker_code) | walker_illegal(v_walker_code);
  assign w_h_en      = w_run && (h_walker_code == GREEN_TWINKLE);
  assign w_v_en      = w_run && (v_walker_code == GREEN_TWINKLE);
  assign w_h_restart = w_h_en && (r_hw_prev != GREEN_TWINKLE);
  assign w_v_restart = w_v_en && (r_vw_prev != GREEN_TWINKLE);

  blink_phase #(.BLINK_HALF(BLINK_HALF)) u_h_blink (
    .clk(clk), .rst(rst), .i_enable(w_h_en), .i_restart(w_h_restart), .o_lit(w_h_lit)
  );

  blink_phase #(.BLINK_HALF(BLINK_HALF)) u_v_blink (
    .clk(clk), .rst(rst), .i_enable(w_v_en), .i_restart(w_v_restart), .o_lit(w_v_lit)
  );

  blink_phase #(.BLINK_HALF(BLINK_HALF)) u_flash (
    .clk(clk), .rst(rst), .i_enable(r_state == ST_FAULT), .i_restart(w_flash_restart),
    .o_lit(w_flash_lit)
  );

  always_comb begin
    w_next_state    = r_state;
    w_h_car_nxt     = 4'b0001;
    w_v_car_nxt     = 4'b0001;
    w_h_wlk_nxt     = 2'b01;
    w_v_wlk_nxt     = 2'b01;
    w_fault_nxt     = r_fault;
    w_cause_nxt     = r_cause;
    w_flash_restart = 1'b0;
    case (r_state)
      ST_ARM: begin
        if (w_arm_done) w_next_state = ST_RUN;
      end
      ST_RUN: begin
        if (w_conf || w_ill) begin
          // The violating combination is never shown: switch straight to flash.
          w_next_state    = ST_FAULT;
          w_fault_nxt     = 1'b1;
          w_cause_nxt     = {w_ill, w_conf};
          w_flash_restart = 1'b1;
          w_h_car_nxt     = {3'b000, w_flash_lit};
          w_v_car_nxt     = {3'b000, w_flash_lit};
          w_h_wlk_nxt     = 2'b00;
          w_v_wlk_nxt     = 2'b00;
        end else begin
          w_h_car_nxt = car_decode(h_car_code);
          w_v_car_nxt = car_decode(v_car_code);
          w_h_wlk_nxt = walker_decode(h_walker_code, w_h_lit);
          w_v_wlk_nxt = walker_decode(v_walker_code, w_v_lit);
        end
      end
      ST_FAULT: begin
        w_h_car_nxt = {3'b000, w_flash_lit};
        w_v_car_nxt = {3'b000, w_flash_lit};
        w_h_wlk_nxt = 2'b00;
        w_v_wlk_nxt = 2'b00;
      end
      default: w_next_state = ST_ARM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_ARM;
      r_arm_cnt <= '0;
      r_hw_prev <= RED;
      r_vw_prev <= RED;
      r_h_car   <= 4'b0001;
      r_v_car   <= 4'b0001;
      r_h_wlk   <= 2'b01;
      r_v_wlk   <= 2'b01;
      r_fault   <= 1'b0;
      r_cause   <= 2'b00;
    end else begin
      r_state   <= w_next_state;
      r_arm_cnt <= (r_state == ST_ARM) ? r_arm_cnt + AW'(1) : '0;
      r_hw_prev <= w_run ? h_walker_code : RED;
      r_vw_prev <= w_run ? v_walker_code : RED;
      r_h_car   <= w_h_car_nxt;
      r_v_car   <= w_v_car_nxt;
      r_h_wlk   <= w_h_wlk_nxt;
      r_v_wlk   <= w_v_wlk_nxt;
      r_fault   <= w_fault_nxt;
      r_cause   <= w_cause_nxt;
    end
  end

  assign h_car_lamp    = r_h_car;
  assign v_car_lamp    = r_v_car;
  assign h_walker_lamp = r_h_wlk;
  assign v_walker_lamp = r_v_wlk;
  assign fault         = r_fault;
  assign fault_cause   = r_cause;

endmodule

// File: tb/tb_signal_lamp_driver.sv
// Directed bench for signal_lamp_driver: phase-sequence table plus hand-written
// ARM, twinkle, fault and reset sequences.
module tb_signal_lamp_driver;

  localparam logic [3:0] C_R   = 4'b0001;
  localparam logic [3:0] C_Y   = 4'b0010;
  localparam logic [3:0] C_G   = 4'b0100;
  localparam logic [3:0] C_L   = 4'b1000;
  localparam logic [3:0] C_OFF = 4'b0000;
  localparam logic [1:0] W_R   = 2'b01;
  localparam logic [1:0] W_G   = 2'b10;
  localparam logic [1:0] W_OFF = 2'b00;

  typedef struct packed {
    logic [2:0] hc;
    logic [2:0] vc;
    logic [2:0] hw;
    logic [2:0] vw;
    logic [3:0] eh;
    logic [3:0] ev;
    logic [1:0] ehw;
    logic [1:0] evw;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] h_car_code = 3'd0;
  logic [2:0] v_car_code = 3'd0;
  logic [2:0] h_walker_code = 3'd0;
  logic [2:0] v_walker_code = 3'd0;
  logic [3:0] h_car_lamp;
  logic [3:0] v_car_lamp;
  logic [1:0] h_walker_lamp;
  logic [1:0] v_walker_lamp;
  logic       fault;
  logic [1:0] fault_cause;

  int n_cmp  = 0;
  int n_fail = 0;
  vec_t tbl [68];

  signal_lamp_driver #(.STARTUP_CYCLES(2), .BLINK_HALF(1)) dut (
    .clk(clk), .rst(rst),
    .h_car_code(h_car_code), .v_car_code(v_car_code),
    .h_walker_code(h_walker_code), .v_walker_code(v_walker_code),
    .h_car_lamp(h_car_lamp), .v_car_lamp(v_car_lamp),
    .h_walker_lamp(h_walker_lamp), .v_walker_lamp(v_walker_lamp),
    .fault(fault), .fault_cause(fault_cause)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] mk(input logic [3:0] h, input logic [3:0] v,
                                     input logic [1:0] hw, input logic [1:0] vw,
                                     input logic f, input logic [1:0] c);
    return {h, v, hw, vw, f, c};
  endfunction

  task automatic chk(input string name, input logic [14:0] exp);
    logic [14:0] act;
    act = {h_car_lamp, v_car_lamp, h_walker_lamp, v_walker_lamp, fault, fault_cause};
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got hcar=%b vcar=%b hw=%b vw=%b f=%b c=%b, want %b_%b_%b_%b_%b_%b",
               name, act[14:11], act[10:7], act[6:5], act[4:3], act[2], act[1:0],
               exp[14:11], exp[10:7], exp[6:5], exp[4:3], exp[2], exp[1:0]);
    end
  endtask

  task automatic drive(input logic [2:0] hc, input logic [2:0] vc,
                       input logic [2:0] hw, input logic [2:0] vw);
    h_car_code = hc; v_car_code = vc; h_walker_code = hw; v_walker_code = vw;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  // Reset with all-red inputs and wait out ARM; next edge samples inputs.
  task automatic fresh_run();
    drive(3'd0, 3'd0, 3'd0, 3'd0);
    do_reset(2);
    repeat (2) tick();
  endtask

  initial begin
    for (int i = 0; i < 68; i++) begin
      vec_t v;
      v = '{hc: 3'd0, vc: 3'd0, hw: 3'd0, vw: 3'd0, eh: C_R, ev: C_R, ehw: W_R, evw: W_R};
      if (i < 19) begin
        v.hc = 3'd1; v.eh = C_G; v.vw = 3'd1; v.evw = W_G;
      end else if (i < 21) begin
        v.hc = 3'd2; v.eh = C_Y;
      end else if (i < 31) begin
        v.hc = 3'd3; v.eh = C_L;
      end else if (i < 33) begin
        v.hc = 3'd2; v.eh = C_Y;
      end else if (i == 33) begin
        v.hc = 3'd0;
      end else if (i < 53) begin
        v.vc = 3'd1; v.ev = C_G; v.hw = 3'd1; v.ehw = W_G;
      end else if (i < 55) begin
        v.vc = 3'd2; v.ev = C_Y;
      end else if (i < 65) begin
        v.vc = 3'd3; v.ev = C_L;
      end else if (i < 67) begin
        v.vc = 3'd2; v.ev = C_Y;
      end
      tbl[i] = v;
    end

    // Reset and ARM with a conflicting car pair held throughout.
    drive(3'd1, 3'd1, 3'd0, 3'd0);
    do_reset(3);
    chk("reset_vals", mk(C_R, C_R, W_R, W_R, 1'b0, 2'b00));
    tick(); chk("arm_edge1", mk(C_R, C_R, W_R, W_R, 1'b0, 2'b00));
    tick(); chk("arm_edge2", mk(C_R, C_R, W_R, W_R, 1'b0, 2'b00));
    tick(); chk("arm_edge3_fault", mk(C_R, C_R, W_OFF, W_OFF, 1'b1, 2'b01));
    tick(); chk("flash_dark", mk(C_OFF, C_OFF, W_OFF, W_OFF, 1'b1, 2'b01));
    tick(); chk("flash_lit", mk(C_R, C_R, W_OFF, W_OFF, 1'b1, 2'b01));

    // Reset mid-fault, then monitoring resumes after ARM.
    rst = 1'b1;
    tick(); chk("rst_midfault", mk(C_R, C_R, W_R, W_R, 1'b0, 2'b00));
    rst = 1'b0;
    tick(); chk("rearm_edge1", mk(C_R, C_R, W_R, W_R, 1'b0, 2'b00));
    tick(); chk("rearm_edge2", mk(C_R, C_R, W_R, W_R, 1'b0, 2'b00));
    tick(); chk("rearm_fault", mk(C_R, C_R, W_OFF, W_OFF, 1'b1, 2'b01));

    // Normal 68-step phase sequence.
    fresh_run();
    for (int i = 0; i < 68; i++) begin
      drive(tbl[i].hc, tbl[i].vc, tbl[i].hw, tbl[i].vw);
      tick();
      chk($sformatf("seq%0d", i), mk(tbl[i].eh, tbl[i].ev, tbl[i].ehw, tbl[i].evw, 1'b0, 2'b00));
    end

    // Twinkle: GREEN then six GREEN_TWINKLE cycles, back to RED, then entry from RED.
    drive(3'd0, 3'd1, 3'd1, 3'd0);
    tick(); chk("tw_green", mk(C_R, C_G, W_G, W_R, 1'b0, 2'b00));
    for (int k = 0; k < 6; k++) begin
      logic [1:0] ew;
      ew = (k % 2 == 0) ? W_G : W_OFF;
      drive(3'd0, 3'd1, 3'd4, 3'd0);
      tick(); chk($sformatf("tw%0d", k), mk(C_R, C_G, ew, W_R, 1'b0, 2'b00));
    end
    drive(3'd0, 3'd1, 3'd0, 3'd0);
    tick(); chk("tw_back_red", mk(C_R, C_G, W_R, W_R, 1'b0, 2'b00));
    drive(3'd0, 3'd1, 3'd4, 3'd0);
    tick(); chk("tw_from_red_lit", mk(C_R, C_G, W_G, W_R, 1'b0, 2'b00));
    tick(); chk("tw_from_red_dark", mk(C_R, C_G, W_OFF, W_R, 1'b0, 2'b00));

    // Illegal walker code.
    drive(3'd0, 3'd0, 3'd0, 3'd3);
    tick(); chk("ill_vwalker", mk(C_R, C_R, W_OFF, W_OFF, 1'b1, 2'b10));

    // Illegal car code on a fresh run.
    fresh_run();
    drive(3'd6, 3'd0, 3'd0, 3'd0);
    tick(); chk("ill_hcar", mk(C_R, C_R, W_OFF, W_OFF, 1'b1, 2'b10));

    // Conflict plus illegal together; cause frozen while inputs turn legal.
    fresh_run();
    drive(3'd1, 3'd2, 3'd0, 3'd7);
    tick(); chk("both_entry", mk(C_R, C_R, W_OFF, W_OFF, 1'b1, 2'b11));
    drive(3'd0, 3'd0, 3'd0, 3'd0);
    tick(); chk("both_dark", mk(C_OFF, C_OFF, W_OFF, W_OFF, 1'b1, 2'b11));
    tick(); chk("both_lit", mk(C_R, C_R, W_OFF, W_OFF, 1'b1, 2'b11));
    tick(); chk("both_dark2", mk(C_OFF, C_OFF, W_OFF, W_OFF, 1'b1, 2'b11));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
